// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential word fetches over an enable/valid port,
// a small prefetch FIFO toward decode, and redirect handling with in-flight discard.
//
// state | meaning
// IDLE  | no fetch outstanding; issue the next one when the FIFO has room
// REQ   | fetch outstanding; the returned word is buffered
// DRAIN | fetch outstanding but superseded by a redirect; the returned word is dropped
module instr_fetch_unit #(
  parameter int                ADDR_W     = 25,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_result,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redir_pc;
  logic [31:0]       instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign redir_pc  = redirect_pc & ~ADDR_W'(3);
  assign out_valid = (count != '0);
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  // Redirect wins over both FIFO operations in the same cycle.
  assign push = (state == REQ) && mem_valid && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      mem_enable <= 1'b0;
      mem_addr   <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
          end else if (count < DEPTH_C) begin
            state      <= REQ;
            mem_enable <= 1'b1;
            mem_addr   <= fetch_pc;
          end
        end
        REQ: begin
          if (mem_valid) begin
            state      <= IDLE;
            mem_enable <= 1'b0;
            fetch_pc   <= redirect ? redir_pc : fetch_pc + ADDR_W'(4);
          end else if (redirect) begin
            // Controller cannot abort: keep the request up and swallow its data.
            state    <= DRAIN;
            fetch_pc <= redir_pc;
          end
        end
        DRAIN: begin
          if (redirect) fetch_pc <= redir_pc;
          if (mem_valid) begin
            state      <= IDLE;
            mem_enable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_result;
      pc_q[wr_ptr]    <= mem_addr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-programmable memory responder plus a
// queue-level model of the delivered instruction stream, checked every cycle.
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 25;
  localparam int          DEPTH    = 4;
  localparam logic [24:0] RESET_PC = 25'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enable;
  logic [24:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_result = '0;
  logic        redirect = 1'b0;
  logic [24:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [24:0] out_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_enable(mem_enable), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_result(mem_result),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  typedef struct packed {
    logic [24:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [24:0] req_log[$];
  logic [24:0] deliv_log[$];
  int          gap_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          busy = 0;
  bit          stale = 0;
  bit          pulse_stale = 0;
  int          lat_left = 0;
  int          latency = 8;
  int          last_valid_cyc = -1;
  int          req_cyc = 0;
  logic [24:0] req_addr = '0;
  logic [24:0] exp_fetch = RESET_PC;

  function automatic logic [31:0] word_of(input logic [24:0] a);
    return {7'b0, a} ^ 32'hA5A5_0000;
  endfunction

  // One clock: apply last cycle's inputs to the model, advance, run the memory, compare.
  task automatic tick();
    ent_t e;
    if (rst) begin
      q.delete(); busy = 0; stale = 0; exp_fetch = RESET_PC;
    end else if (redirect) begin
      q.delete();
      exp_fetch = redirect_pc & ~25'd3;
      if (busy) stale = 1;
    end else begin
      if (q.size() != 0 && out_ready) begin
        deliv_log.push_back(out_pc);
        void'(q.pop_front());
      end
      if (mem_valid && !pulse_stale) begin
        e.pc = req_addr; e.instr = word_of(req_addr);
        q.push_back(e);
        exp_fetch = req_addr + 25'd4;
      end
    end
    @(posedge clk); #1; cyc++;
    mem_valid = 0; redirect = 0;
    if (!rst) begin
      if (busy) begin
        checks++;
        if (mem_enable !== 1'b1 || mem_addr !== req_addr) begin
          errors++;
          $display("FAIL hold_request cyc=%0d got en=%b addr=%h exp en=1 addr=%h", cyc, mem_enable, mem_addr, req_addr);
        end
        lat_left--;
        if (lat_left == 0) begin
          mem_valid = 1; mem_result = word_of(req_addr);
          busy = 0; pulse_stale = stale; stale = 0; last_valid_cyc = cyc;
        end
      end else if (mem_enable === 1'b1) begin
        checks++;
        if (mem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL request_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_fetch);
        end
        checks++;
        if (q.size() >= DEPTH) begin
          errors++;
          $display("FAIL request_room cyc=%0d got entries=%0d exp <%0d", cyc, q.size(), DEPTH);
        end
        if (last_valid_cyc >= 0) gap_log.push_back(cyc - last_valid_cyc);
        busy = 1; stale = 0; req_addr = mem_addr; lat_left = latency; req_cyc = cyc;
        req_log.push_back(mem_addr);
      end
    end
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if (out_pc !== q[0].pc || out_instr !== q[0].instr) begin
        errors++;
        $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc, out_pc, out_instr, q[0].pc, q[0].instr);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; redirect = 0;
    tick(); tick();
    rst = 0;
    req_log.delete(); deliv_log.delete(); gap_log.delete(); last_valid_cyc = -1;
  endtask

  task automatic test_reset();
    latency = 8; out_ready = 1;
    do_reset();
    checks++;
    if (mem_enable !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b valid=%b exp en=0 valid=0", mem_enable, out_valid);
    end
    tick();
    checks++;
    if (mem_enable !== 1'b1 || mem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_request got en=%b addr=%h exp en=1 addr=%h", mem_enable, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int n = 0;
    while (!(req_log.size() >= 4 && deliv_log.size() >= 3) && n < 200) begin tick(); n++; end
    checks++;
    if (req_log.size() < 4 || deliv_log.size() < 3 || gap_log.size() < 2) begin
      errors++;
      $display("FAIL stream_timeout got req=%0d deliv=%0d exp req>=4 deliv>=3", req_log.size(), deliv_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_log[i] !== 25'(4 * i) || deliv_log[i] !== 25'(4 * i)) begin
          errors++;
          $display("FAIL stream_seq[%0d] got req=%h deliv=%h exp %h", i, req_log[i], deliv_log[i], 25'(4 * i));
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (gap_log[i] != 2) begin
          errors++;
          $display("FAIL enable_gap[%0d] got=%0d exp=2", i, gap_log[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    int n = 0;
    int bad = 0;
    latency = 2; out_ready = 0;
    do_reset();
    while (q.size() != DEPTH && n < 100) begin tick(); n++; end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_enable !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || req_log.size() != DEPTH || out_pc !== 25'h0) begin
      errors++;
      $display("FAIL full_hold got en_cycles=%0d reqs=%0d head=%h exp 0 %0d 0", bad, req_log.size(), out_pc, DEPTH);
    end
    out_ready = 1; tick(); out_ready = 0;
    n = 0;
    while (mem_enable !== 1'b1 && n < 3) begin tick(); n++; end
    checks++;
    if (mem_enable !== 1'b1 || mem_addr !== 25'h10 || n > 1 || out_pc !== 25'h4) begin
      errors++;
      $display("FAIL full_resume got en=%b addr=%h wait=%0d head=%h exp en=1 addr=10 wait<=1 head=4", mem_enable, mem_addr, n, out_pc);
    end
  endtask

  task automatic test_redirect_inflight();
    int n = 0;
    int bad = 0;
    int n0;
    latency = 8; out_ready = 0;
    do_reset();
    while (!(busy && req_addr == 25'h8) && n < 100) begin tick(); n++; end
    tick(); tick();
    n0 = req_log.size();
    redirect = 1; redirect_pc = 25'h40;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush got valid=%b exp=0", out_valid);
    end
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin
      if (mem_enable !== 1'b1 || mem_addr !== 25'h8) bad++;
      tick(); n++;
    end
    checks++;
    if (bad != 0 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_hold got bad_cycles=%0d pulse=%b exp 0 1", bad, mem_valid);
    end
    deliv_log.delete(); out_ready = 1;
    n = 0;
    while (deliv_log.size() < 2 && n < 60) begin tick(); n++; end
    checks++;
    if (req_log.size() <= n0 || deliv_log.size() < 2) begin
      errors++;
      $display("FAIL redir_timeout got reqs=%0d deliv=%0d exp >%0d >=2", req_log.size(), deliv_log.size(), n0);
    end else if (req_log[n0] !== 25'h40 || deliv_log[0] !== 25'h40 || deliv_log[1] !== 25'h44) begin
      errors++;
      $display("FAIL redir_stream got req=%h deliv=%h,%h exp 40 40,44", req_log[n0], deliv_log[0], deliv_log[1]);
    end
  endtask

  task automatic test_redirect_on_valid();
    int n = 0;
    int n0;
    int vcyc;
    latency = 4; out_ready = 1;
    do_reset();
    while (!(mem_valid === 1'b1 && req_addr == 25'h4) && n < 100) begin tick(); n++; end
    redirect = 1; redirect_pc = 25'h103;
    vcyc = cyc; n0 = req_log.size(); deliv_log.delete();
    tick();
    n = 0;
    while (req_log.size() <= n0 && n < 10) begin tick(); n++; end
    checks++;
    if (req_log.size() <= n0 || req_log[n0] !== 25'h100 || req_cyc - vcyc != 2) begin
      errors++;
      $display("FAIL valid_redir_req got reqs=%0d delay=%0d exp addr=100 delay=2", req_log.size(), req_cyc - vcyc);
    end
    n = 0;
    while (deliv_log.size() < 1 && n < 30) begin tick(); n++; end
    checks++;
    if (deliv_log.size() < 1 || deliv_log[0] !== 25'h100) begin
      errors++;
      $display("FAIL valid_redir_drop got deliv=%0d exp first pc=100", deliv_log.size());
    end
  endtask

  task automatic test_double_redirect();
    int n = 0;
    int n0;
    latency = 12; out_ready = 1;
    do_reset();
    while (!busy && n < 20) begin tick(); n++; end
    tick();
    n0 = req_log.size(); deliv_log.delete();
    redirect = 1; redirect_pc = 25'h80;
    tick(); tick();
    redirect = 1; redirect_pc = 25'hC0;
    tick();
    latency = 3;
    n = 0;
    while (deliv_log.size() < 3 && n < 200) begin tick(); n++; end
    checks++;
    if (deliv_log.size() < 3 || req_log.size() <= n0) begin
      errors++;
      $display("FAIL drain_timeout got deliv=%0d exp >=3", deliv_log.size());
    end else if (req_log[n0] !== 25'hC0 || deliv_log[0] !== 25'hC0 || deliv_log[1] !== 25'hC4 || deliv_log[2] !== 25'hC8) begin
      errors++;
      $display("FAIL drain_last_wins got req=%h deliv=%h,%h,%h exp c0 c0,c4,c8", req_log[n0], deliv_log[0], deliv_log[1], deliv_log[2]);
    end
  endtask

  task automatic test_push_pop();
    int n = 0;
    latency = 3; out_ready = 0;
    do_reset();
    while (!(q.size() == 2 && mem_valid === 1'b1) && n < 100) begin tick(); n++; end
    out_ready = 1; tick(); out_ready = 0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 25'h4 || out_instr !== word_of(25'h4)) begin
      errors++;
      $display("FAIL pushpop_head got valid=%b pc=%h instr=%h exp 1 4 %h", out_valid, out_pc, out_instr, word_of(25'h4));
    end
    n = 0;
    while (q.size() != DEPTH && n < 60) begin tick(); n++; end
    deliv_log.delete();
    out_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 0;
    checks++;
    if (deliv_log.size() != 4) begin
      errors++;
      $display("FAIL pushpop_count got deliv=%0d exp=4", deliv_log.size());
    end else if (deliv_log[0] !== 25'h4 || deliv_log[1] !== 25'h8 || deliv_log[2] !== 25'hC || deliv_log[3] !== 25'h10) begin
      errors++;
      $display("FAIL pushpop_order got %h,%h,%h,%h exp 4,8,c,10", deliv_log[0], deliv_log[1], deliv_log[2], deliv_log[3]);
    end
  endtask

  task automatic test_reset_midreq();
    int n = 0;
    latency = 8; out_ready = 1;
    do_reset();
    while (!(busy && req_addr == 25'h4) && n < 100) begin tick(); n++; end
    tick();
    rst = 1; tick();
    checks++;
    if (mem_enable !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreq_reset got en=%b valid=%b exp 0 0", mem_enable, out_valid);
    end
    rst = 0; tick();
    checks++;
    if (mem_enable !== 1'b1 || mem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midreq_restart got en=%b addr=%h exp 1 %h", mem_enable, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int n0;
    latency = 2; out_ready = 1;
    do_reset();
    tick(); tick();
    n0 = req_log.size();
    redirect = 1; redirect_pc = 25'h1FF_FFFE;
    tick();
    while (req_log.size() < n0 + 2 && n < 40) begin tick(); n++; end
    checks++;
    if (req_log.size() < n0 + 2) begin
      errors++;
      $display("FAIL wrap_timeout got reqs=%0d exp >=%0d", req_log.size(), n0 + 2);
    end else if (req_log[n0] !== 25'h1FF_FFFC || req_log[n0 + 1] !== 25'h0) begin
      errors++;
      $display("FAIL wrap_pc got %h,%h exp 1fffffc,0", req_log[n0], req_log[n0 + 1]);
    end
  endtask

  task automatic test_random();
    out_ready = 1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      latency   = $urandom_range(1, 6);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect = 1; redirect_pc = 25'($urandom());
      end
      tick();
    end
    checks++;
    if (deliv_log.size() < 50) begin
      errors++;
      $display("FAIL random_progress got deliv=%0d exp >=50", deliv_log.size());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_inflight();
    test_redirect_on_valid();
    test_double_redirect();
    test_push_pop();
    test_reset_midreq();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
